// File: rtl/clock_gate_controller.sv
// Run sequencer for the core's glitchless clock-gating buffer: opens gate_n for a budgeted run, drains, reports.
// Optional single-step support is enabled by defining CLOCK_GATE_SINGLE_STEP_EN (adds the step input).
module clock_gate_controller #(
    parameter int COUNT_WIDTH  = 48,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start_valid,
    output logic                   start_ready,
    input  logic [COUNT_WIDTH-1:0] start_budget,
    input  logic                   stop_req,
    input  logic                   core_halt,
    output logic                   gate_n,
    output logic                   running,
    output logic                   done_valid,
    input  logic                   done_ready,
    output logic [1:0]             done_cause,
    output logic [COUNT_WIDTH-1:0] cycle_count
`ifdef CLOCK_GATE_SINGLE_STEP_EN
    ,
    input  logic                   step
`endif
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3,
        ST_STEP  = 3'd4
    } state_t;

    state_t                 state_r;
    state_t                 state_next_s;
    logic [COUNT_WIDTH-1:0] remaining_r;
    logic                   unbounded_r;
    logic [DW-1:0]          drain_r;
    logic                   run_exit_s;
    logic                   step_s;
    logic                   gate_n_next_s;
    logic                   running_next_s;
    logic                   start_ready_next_s;
    logic                   done_valid_next_s;

`ifdef CLOCK_GATE_SINGLE_STEP_EN
    assign step_s = step;
`else
    assign step_s = 1'b0;
`endif

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        if (v == {COUNT_WIDTH{1'b1}}) begin
            return v;
        end else begin
            return v + CNT_ONE;
        end
    endfunction

    // Halt outranks host stop, which outranks budget exhaustion.
    function automatic logic [1:0] exit_cause(input logic halt, input logic stop);
        if (halt) begin
            return 2'b10;
        end else if (stop) begin
            return 2'b01;
        end else begin
            return 2'b00;
        end
    endfunction

    assign run_exit_s = core_halt || stop_req || (!unbounded_r && (remaining_r == CNT_ONE));

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_valid) begin
                    state_next_s = ST_RUN;
                end else if (step_s) begin
                    state_next_s = ST_STEP;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (run_exit_s) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (drain_r == DRAIN_LAST) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (done_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            ST_STEP: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so every output leaves a flop.
    always_comb begin
        gate_n_next_s      = 1'b1;
        running_next_s     = 1'b0;
        start_ready_next_s = 1'b0;
        done_valid_next_s  = 1'b0;
        case (state_next_s)
            ST_IDLE:  start_ready_next_s = 1'b1;
            ST_RUN: begin
                gate_n_next_s  = 1'b0;
                running_next_s = 1'b1;
            end
            ST_STEP:  gate_n_next_s = 1'b0;
            ST_DONE:  done_valid_next_s = 1'b1;
            ST_DRAIN: gate_n_next_s = 1'b1;
            default:  gate_n_next_s = 1'b1;
        endcase
    end

    // Output registers; reset forces the gate closed asynchronously.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            gate_n      <= 1'b1;
            running     <= 1'b0;
            start_ready <= 1'b1;
            done_valid  <= 1'b0;
        end else begin
            gate_n      <= gate_n_next_s;
            running     <= running_next_s;
            start_ready <= start_ready_next_s;
            done_valid  <= done_valid_next_s;
        end
    end

    // Budget, cycle counter, drain timer and exit cause.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            remaining_r <= {COUNT_WIDTH{1'b0}};
            unbounded_r <= 1'b0;
            drain_r     <= {DW{1'b0}};
            done_cause  <= 2'b00;
            cycle_count <= {COUNT_WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_valid) begin
                        remaining_r <= start_budget;
                        unbounded_r <= (start_budget == {COUNT_WIDTH{1'b0}});
                        cycle_count <= {COUNT_WIDTH{1'b0}};
                    end
                end
                ST_RUN: begin
                    cycle_count <= sat_inc(cycle_count);
                    drain_r     <= {DW{1'b0}};
                    if (!unbounded_r) begin
                        remaining_r <= remaining_r - CNT_ONE;
                    end
                    if (run_exit_s) begin
                        done_cause <= exit_cause(core_halt, stop_req);
                    end
                end
                ST_DRAIN: drain_r     <= drain_r + {{(DW-1){1'b0}}, 1'b1};
                ST_STEP:  cycle_count <= sat_inc(cycle_count);
                default:  drain_r     <= drain_r;
            endcase
        end
    end

endmodule

// File: tb/tb_clock_gate_controller.sv
// Randomised and directed bench for clock_gate_controller against a run-level behavioural model.
module tb_clock_gate_controller;

    localparam int CW    = 48;
    localparam int DRAIN = 2;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          start_valid;
    logic          start_ready;
    logic [CW-1:0] start_budget;
    logic          stop_req;
    logic          core_halt;
    logic          gate_n;
    logic          running;
    logic          done_valid;
    logic          done_ready;
    logic [1:0]    done_cause;
    logic [CW-1:0] cycle_count;
    logic          step = 1'b0;

    int vectors    = 0;
    int miscompares = 0;
    bit chk_en     = 1'b0;

    // Model: a run is "busy" from accept until the result is consumed.
    bit            m_busy, m_open, m_stepping;
    logic [CW-1:0] m_cnt, m_budget;
    logic [1:0]    m_cause;
    int            m_drain;

    clock_gate_controller #(.COUNT_WIDTH(CW), .DRAIN_CYCLES(DRAIN)) dut (
        .clock(clock), .reset_n(reset_n),
        .start_valid(start_valid), .start_ready(start_ready), .start_budget(start_budget),
        .stop_req(stop_req), .core_halt(core_halt),
        .gate_n(gate_n), .running(running),
        .done_valid(done_valid), .done_ready(done_ready),
        .done_cause(done_cause), .cycle_count(cycle_count)
`ifdef CLOCK_GATE_SINGLE_STEP_EN
        , .step(step)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [CW-1:0] sat(input logic [CW-1:0] v);
        logic [CW-1:0] ones;
        ones = '1;
        return (v == ones) ? v : v + CW'(1);
    endfunction

    task automatic model_reset();
        m_busy = 0; m_open = 0; m_stepping = 0;
        m_cnt = '0; m_budget = '0; m_cause = 2'b00; m_drain = 0;
    endtask

    task automatic close_run(input logic [1:0] c);
        m_cause = c; m_open = 0; m_drain = DRAIN;
    endtask

    // Advance the model by one edge using the inputs present before that edge.
    task automatic model_step();
        if (m_stepping) begin
            m_cnt = sat(m_cnt);
            m_stepping = 0;
        end else if (!m_busy) begin
            if (start_valid) begin
                m_busy = 1; m_open = 1; m_cnt = '0; m_budget = start_budget;
            end else if (step) begin
                m_stepping = 1;
            end
        end else if (m_open) begin
            m_cnt = sat(m_cnt);
            if (core_halt) close_run(2'b10);
            else if (stop_req) close_run(2'b01);
            else if (m_budget != '0 && m_cnt == m_budget) close_run(2'b00);
        end else if (m_drain > 0) begin
            m_drain--;
        end else if (done_ready) begin
            m_busy = 0;
        end
    endtask

    // Compare DUT outputs with the model every cycle, mid-period.
    always @(negedge clock) begin
        if (chk_en) begin
            check("gate_n", gate_n, !(m_open || m_stepping));
            check("running", running, m_open);
            check("start_ready", start_ready, !m_busy && !m_stepping);
            check("done_valid", done_valid, m_busy && !m_open && m_drain == 0);
            check("done_cause", done_cause, m_cause);
            check("cycle_count", cycle_count, m_cnt);
        end
    end

    task automatic tick();
        @(posedge clock);
        if (reset_n) model_step();
        #1;
    endtask

    task automatic start_run(input logic [CW-1:0] b);
        start_valid = 1'b1; start_budget = b;
        tick();
        start_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 80 && !done_valid; i++) tick();
        check("done_timeout", done_valid, 1'b1);
    endtask

    task automatic ack();
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
    endtask

    initial begin
        int n;
        reset_n = 1'b0; start_valid = 0; start_budget = '0; stop_req = 0; core_halt = 0; done_ready = 0;
        model_reset();
        chk_en = 1'b1;
        #12;
        check("rst_gate_n", gate_n, 1'b1);
        check("rst_start_ready", start_ready, 1'b1);
        check("rst_count", cycle_count, 0);
        #10 reset_n = 1'b1;
        tick();

        // Budget 5: five open cycles, done two cycles after the gate closes.
        start_run(CW'(5));
        n = 0;
        while (gate_n == 1'b0 && n < 30) begin n++; tick(); end
        check("b5_open_cycles", n, 5);
        n = 0;
        while (!done_valid && n < 20) begin n++; tick(); end
        check("b5_done_delay", n, 2);
        check("b5_cause", done_cause, 2'b00);
        check("b5_count", cycle_count, 5);
        ack();
        check("b5_done_fall", done_valid, 1'b0);

        // Budget 1 gives one open cycle.
        start_run(CW'(1));
        n = 0;
        while (gate_n == 1'b0 && n < 30) begin n++; tick(); end
        check("b1_open_cycles", n, 1);
        wait_done();
        ack();

        // Unbounded run stopped in its 17th cycle.
        start_run('0);
        repeat (16) tick();
        stop_req = 1'b1;
        tick();
        stop_req = 1'b0;
        check("stop_gate_n", gate_n, 1'b1);
        check("stop_count", cycle_count, 17);
        wait_done();
        check("stop_cause", done_cause, 2'b01);
        ack();

        // Halt and stop together on the final budget cycle.
        start_run(CW'(8));
        repeat (7) tick();
        stop_req = 1'b1; core_halt = 1'b1;
        tick();
        stop_req = 1'b0; core_halt = 1'b0;
        wait_done();
        check("both_cause", done_cause, 2'b10);
        check("both_count", cycle_count, 8);
        ack();

        // Result held while done_ready is low; pending start waits for IDLE.
        start_run(CW'(3));
        wait_done();
        start_valid = 1'b1; start_budget = CW'(4);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_valid", done_valid, 1'b1);
            check("hold_ready", start_ready, 1'b0);
        end
        ack();
        check("idle_ready", start_ready, 1'b1);
        check("idle_count_kept", cycle_count, 3);
        tick();
        start_valid = 1'b0;
        check("accept_running", running, 1'b1);
        check("accept_count_clear", cycle_count, 0);
        wait_done();
        check("hs4_count", cycle_count, 4);
        ack();

        // Asynchronous reset mid-run.
        start_run('0);
        repeat (3) tick();
        check("pre_rst_count", cycle_count, 3);
        #1 reset_n = 1'b0;
        model_reset();
        #1;
        check("arst_gate_n", gate_n, 1'b1);
        check("arst_running", running, 1'b0);
        check("arst_done_valid", done_valid, 1'b0);
        check("arst_count", cycle_count, 0);
        stop_req = 1'b1;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_stop_gate", gate_n, 1'b1);
        end
        stop_req = 1'b0;

`ifdef CLOCK_GATE_SINGLE_STEP_EN
        for (int i = 0; i < 3; i++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            check("step_open", gate_n, 1'b0);
            tick();
            check("step_closed", gate_n, 1'b1);
            tick();
        end
        check("step_count", cycle_count, 3);
`endif

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            start_valid  = ($urandom % 4) == 0;
            start_budget = (($urandom % 5) == 0) ? '0 : CW'($urandom_range(1, 12));
            stop_req     = ($urandom % 25) == 0;
            core_halt    = ($urandom % 30) == 0;
            done_ready   = ($urandom % 2) == 0;
`ifdef CLOCK_GATE_SINGLE_STEP_EN
            step         = ($urandom % 10) == 0;
`endif
            tick();
        end
        #4;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
